// File: rtl/icache_dm.sv
// -----------------------------------------------------------------------------
// icache_dm : direct-mapped, read-only instruction cache.
//
// Serves single-word fetches from the CPU fetch stage. A hit is answered in
// the same cycle (combinational response in IDLE). A miss refills a whole
// 256-bit line from physical memory, then the still-held request hits.
//
// Ports
//   clk, rst          clock; asynchronous active-low reset
//   icache_addr/read  fetch request (address held stable until icache_resp)
//   icache_rdata/resp fetched word and its valid strobe
//   flush             single-cycle invalidate-all pulse
//   pmem_addr/read    line refill request (held until pmem_resp)
//   pmem_rdata/resp   refill line and its single-cycle completion strobe
//   hit_count         saturating count of IDLE cycles that hit
//   miss_count        saturating count of IDLE->FILL transitions
// -----------------------------------------------------------------------------
module icache_dm #(
    parameter int NUM_SETS = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      icache_addr,
    input  logic             icache_read,
    output logic [31:0]      icache_rdata,
    output logic             icache_resp,
    input  logic             flush,
    output logic [31:0]      pmem_addr,
    output logic             pmem_read,
    input  logic [255:0]     pmem_rdata,
    input  logic             pmem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX = $clog2(NUM_SETS);
    localparam int TAG = 27 - IDX;

    typedef enum logic {IDLE, FILL} state_t;

    state_t state, state_next;

    logic [NUM_SETS-1:0] valid;
    logic [TAG-1:0]      tag_mem  [NUM_SETS];
    logic [255:0]        data_mem [NUM_SETS];

    // Line address (addr[31:5]) of the refill in progress.
    logic [26:0] fill_addr;

    logic [IDX-1:0] req_idx;
    logic [TAG-1:0] req_tag;
    logic [IDX-1:0] fill_idx;
    logic [TAG-1:0] fill_tag;
    logic [255:0]   line_sel;
    logic           hit;
    logic           hit_idle;
    logic           miss_start;
    logic           fill_done;
    logic           unused_byte_bits;

    assign req_idx  = icache_addr[5+IDX-1:5];
    assign req_tag  = icache_addr[31:5+IDX];
    assign fill_idx = fill_addr[IDX-1:0];
    assign fill_tag = fill_addr[26:IDX];
    assign line_sel = data_mem[req_idx];

    // Fetches are word-aligned; the byte offset never selects anything.
    assign unused_byte_bits = ^icache_addr[1:0];

    // The valid bit gates the compare, so unwritten tag entries never matter.
    assign hit        = icache_read & valid[req_idx] & (tag_mem[req_idx] == req_tag);
    assign hit_idle   = (state == IDLE) & hit;
    assign miss_start = (state == IDLE) & icache_read & ~hit;
    assign fill_done  = (state == FILL) & pmem_resp;

    // Invalid sets read as zero so rdata is never X after reset.
    assign icache_rdata = valid[req_idx] ? line_sel[{icache_addr[4:2], 5'b0} +: 32] : 32'h0;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (icache_read && !hit) state_next = FILL;
            FILL:    if (pmem_resp)           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        icache_resp = 1'b0;
        pmem_read   = 1'b0;
        pmem_addr   = 32'h0;
        case (state)
            IDLE: icache_resp = hit;
            FILL: begin
                pmem_read = 1'b1;
                pmem_addr = {fill_addr, 5'b0};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------ storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            fill_addr <= '0;
        else if (miss_start) fill_addr <= icache_addr[31:5];
    end

    // Flush has priority over a coincident install: that set stays invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           valid <= '0;
        else if (flush)     valid <= '0;
        else if (fill_done) valid[fill_idx] <= 1'b1;
    end

    // NOTE: tag and data arrays are deliberately not reset; valid alone
    // decides whether their contents are meaningful.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= pmem_rdata;
        end
    end

    // ------------------------------------------------------ counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_idle && hit_count != '1)    hit_count  <= hit_count + CNT_W'(1);
            if (miss_start && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// -----------------------------------------------------------------------------
// tb_icache_dm : scoreboard bench for icache_dm.
//
// The driver issues fetches and plays the memory side; for each fetch that
// should respond it pushes the expected word into a queue. A forked monitor
// pops and compares on every icache_resp. The reference model tracks which
// line address is resident in each set and the expected counter values.
// Counters are built 4 bits wide so saturation is reached by the random run.
// -----------------------------------------------------------------------------
module tb_icache_dm;

    localparam int NUM_SETS = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = 15;
    localparam int LIMIT    = 60;

    logic             clk;
    logic             rst;
    logic [31:0]      icache_addr;
    logic             icache_read;
    logic [31:0]      icache_rdata;
    logic             icache_resp;
    logic             flush;
    logic [31:0]      pmem_addr;
    logic             pmem_read;
    logic [255:0]     pmem_rdata;
    logic             pmem_resp;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    icache_dm #(.NUM_SETS(NUM_SETS), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .icache_addr  (icache_addr),
        .icache_read  (icache_read),
        .icache_rdata (icache_rdata),
        .icache_resp  (icache_resp),
        .flush        (flush),
        .pmem_addr    (pmem_addr),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    logic [26:0] resident[int];   // set index -> resident line address
    int          exp_hits   = 0;
    int          exp_misses = 0;

    // Mode of a fetch that misses: how the fill is disturbed.
    localparam int M_NORMAL    = 0;
    localparam int M_DROP      = 1;   // requester drops read during FILL
    localparam int M_FLUSH_RSP = 2;   // flush coincides with pmem_resp
    localparam int M_FLUSH_MID = 3;   // flush in FILL before pmem_resp

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: word at 0x40 is A5A5_0000, increasing by one per word.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA5A5_0000 + {2'b00, a[31:2]} - 32'h10;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = word_of({a[31:5], 5'b0} + 32'(4*i));
        return l;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : CNT_MAX;
    endfunction

    // All driver tasks start and end at posedge+1.
    task automatic check_counters(input string tag);
        @(negedge clk);
        check({tag, "_hit_count"},  64'(hit_count),  64'(exp_hits));
        check({tag, "_miss_count"}, 64'(miss_count), 64'(exp_misses));
        @(posedge clk); #1;
    endtask

    task automatic flush_pulse();
        icache_read = 1'b0;
        flush       = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        resident.delete();
    endtask

    task automatic idle_cycle();
        icache_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input int lat, input int mode_in);
        logic [26:0] line;
        int          set, mode, exp_cyc, fill_k, cyc;
        bit          exp_hit, got, resp_driven, flush_pending, done;

        line    = addr[31:5];
        set     = int'(line % NUM_SETS);
        exp_hit = resident.exists(set) && (resident[set] == line);
        mode    = exp_hit ? M_NORMAL : mode_in;
        if (mode == M_FLUSH_MID && lat == 0) mode = M_NORMAL;

        if (exp_hit)                   exp_cyc = 0;
        else if (mode == M_FLUSH_RSP)  exp_cyc = 2 * (2 + lat);
        else                           exp_cyc = 2 + lat;

        if (mode != M_DROP) sb_q.push_back(word_of(addr));
        icache_addr   = addr;
        icache_read   = 1'b1;
        fill_k        = 0;
        cyc           = 0;
        done          = 1'b0;
        flush_pending = (mode == M_FLUSH_RSP);

        while (!done) begin
            resp_driven = 1'b0;
            if (exp_hit) check("pmem_read_on_hit", 64'(pmem_read), 64'd0);
            if (pmem_read) begin
                check("pmem_addr", 64'(pmem_addr), 64'({line, 5'b0}));
                if (fill_k == lat) begin
                    pmem_resp   = 1'b1;
                    pmem_rdata  = line_of(addr);
                    resp_driven = 1'b1;
                    fill_k      = 0;
                    if (flush_pending) begin
                        flush         = 1'b1;
                        flush_pending = 1'b0;
                    end
                end else begin
                    if (mode == M_FLUSH_MID && fill_k == 0) flush = 1'b1;
                    fill_k++;
                end
            end
            if (mode == M_DROP && cyc == 1) icache_read = 1'b0;
            @(negedge clk);
            got = icache_resp;
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            flush     = 1'b0;
            if (mode == M_DROP) begin
                done = resp_driven;
            end else if (got) begin
                check("latency", 64'(cyc), 64'(exp_cyc));
                done = 1'b1;
            end
            cyc++;
            if (!done && cyc > LIMIT) begin
                n_checks++;
                n_errors++;
                $display("FAIL timeout: addr %0h got no completion within %0d cycles", addr, LIMIT);
                done = 1'b1;
            end
        end
        icache_read = 1'b0;

        if (!exp_hit) begin
            exp_misses = sat_inc(exp_misses);
            if (mode == M_FLUSH_RSP) exp_misses = sat_inc(exp_misses);
            if (mode == M_FLUSH_RSP || mode == M_FLUSH_MID) resident.delete();
            resident[set] = line;
        end
        if (mode != M_DROP) exp_hits = sat_inc(exp_hits);
    endtask

    initial begin
        rst         = 1'b0;
        icache_addr = 32'h0;
        icache_read = 1'b0;
        flush       = 1'b0;
        pmem_rdata  = '0;
        pmem_resp   = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (icache_resp) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_resp: got resp with rdata %0h, expected none at %0t",
                                 icache_rdata, $time);
                    end else begin
                        check("rdata", 64'(icache_rdata), 64'(sb_q.pop_front()));
                    end
                end
            end
        join_none

        // Reset state
        #12;
        check("rst_icache_resp", 64'(icache_resp),  64'd0);
        check("rst_pmem_read",   64'(pmem_read),    64'd0);
        check("rst_pmem_addr",   64'(pmem_addr),    64'd0);
        check("rst_icache_rdata",64'(icache_rdata), 64'd0);
        check("rst_hit_count",   64'(hit_count),    64'd0);
        check("rst_miss_count",  64'(miss_count),   64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 1: cold miss, memory wait 3
        do_read(32'h0000_0040, 3, M_NORMAL);
        check_counters("t1");

        // 2: streaming hits over the rest of the line
        for (int w = 1; w < 8; w++) do_read(32'h40 + 32'(4*w), 0, M_NORMAL);
        check_counters("t2");

        // 3: conflict eviction on set 2
        flush_pulse();
        do_read(32'h040, 1, M_NORMAL);
        do_read(32'h140, 2, M_NORMAL);
        do_read(32'h040, 0, M_NORMAL);
        check_counters("t3");

        // 4: flush then refetch; flush coincident with pmem_resp
        do_read(32'h040, 0, M_NORMAL);
        flush_pulse();
        do_read(32'h040, 2, M_NORMAL);
        do_read(32'h080, 1, M_FLUSH_RSP);
        do_read(32'h0C0, 2, M_FLUSH_MID);
        do_read(32'h080, 0, M_NORMAL);
        check_counters("t4");

        // 5: abandoned request, then zero-wait memory
        do_read(32'h0A0, 2, M_DROP);
        idle_cycle();
        do_read(32'h0A4, 0, M_NORMAL);
        do_read(32'h200, 0, M_NORMAL);
        check_counters("t5");

        // 6: async reset in the middle of a fill
        flush_pulse();
        icache_addr = 32'h0000_0300;
        icache_read = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        check("fill_pmem_read", 64'(pmem_read), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_pmem_read",  64'(pmem_read),   64'd0);
        check("arst_pmem_addr",  64'(pmem_addr),   64'd0);
        check("arst_icache_resp",64'(icache_resp), 64'd0);
        check("arst_hit_count",  64'(hit_count),   64'd0);
        check("arst_miss_count", 64'(miss_count),  64'd0);
        icache_read = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        resident.delete();
        exp_hits   = 0;
        exp_misses = 0;
        do_read(32'h040, 1, M_NORMAL);
        check_counters("t6");

        // Randomized traffic over a small footprint that forces conflicts
        for (int n = 0; n < 200; n++) begin
            int m;
            m = int'($urandom_range(0, 9));
            if (m > 3) m = M_NORMAL;
            do_read($urandom_range(0, 1023), int'($urandom_range(0, 3)), m);
            if ($urandom_range(0, 19) == 0) flush_pulse();
            if ($urandom_range(0, 7) == 0)  idle_cycle();
            if (n % 25 == 24) check_counters("rand");
        end
        check_counters("final");
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
